arb_mux: RTL

Registered N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and built-in arbitration. It is the parametrised successor to the fixed 2:1 16-bit select mux. Selection is made by an internal arbiter, round-robin or fixed-priority, instead of an external select line. The result is held in a one-entry output register. It sits wherever several producers share one consumer, such as register-file write ports or bus masters onto a shared data path.

---
 rtl/arb_mux.sv | 114 +++++++++++
 1 files changed

// File: rtl/arb_mux.sv
// ---------------------------------------------------------------------------
// ArbMux (module arb_mux)
// Registered N-channel stream multiplexer with a built-in arbiter. Several
// producers offer words over valid/ready handshakes; the arbiter picks one
// (round-robin or fixed lowest-index priority) and the chosen word is captured
// in a one-entry output register that the consumer drains with i_out_ready.
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset
//   i_prio_mode  0 = round-robin, 1 = fixed priority (lowest index wins)
//   i_in_valid   per-channel valid
//   i_in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   o_in_ready   per-channel accept strobe, at most one bit high
//   o_out_valid  output register holds a word
//   o_out_data   held word
//   o_out_sel    index of the channel that produced o_out_data
//   i_out_ready  consumer takes the held word this cycle
// ---------------------------------------------------------------------------
module arb_mux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_prio_mode,
   input  logic [CHANNELS-1:0]       i_in_valid,
   input  logic [CHANNELS*WIDTH-1:0] i_in_data,
   output logic [CHANNELS-1:0]       o_in_ready,
   output logic                      o_out_valid,
   output logic [WIDTH-1:0]          o_out_data,
   output logic [SEL_W-1:0]          o_out_sel,
   input  logic                      i_out_ready
);

   logic               r_outValid;
   logic [WIDTH-1:0]   r_outData;
   logic [SEL_W-1:0]   r_outSel;
   logic [SEL_W-1:0]   r_last;

   logic               w_load;
   logic               w_anyValid;
   logic [SEL_W-1:0]   w_grantIdx;
   logic [WIDTH-1:0]   w_grantData;
   logic [CHANNELS-1:0] w_inReady;
   logic [WIDTH-1:0]   w_chanData [CHANNELS];

   // Unpack the flat data bus so channels can be picked by index
   for (genvar g = 0; g < CHANNELS; g++) begin : gUnpack
      assign w_chanData[g] = i_in_data[g*WIDTH +: WIDTH];
   end

   // The register may take a new word when empty or being drained this cycle
   assign w_load = !r_outValid || i_out_ready;

   // Arbiter: walk the channels in search order and keep the first valid one.
   // Fixed priority searches 0,1,2,...; round-robin starts just after the
   // last grant and wraps, so the last winner is visited only at the very end.
   always_comb begin
      w_anyValid  = 1'b0;
      w_grantIdx  = '0;
      w_grantData = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         int               candInt;
         logic [SEL_W-1:0] cand;
         if (i_prio_mode)
            candInt = k;
         else
            candInt = (int'(r_last) + 1 + k) % CHANNELS;
         cand = SEL_W'(candInt);
         if (!w_anyValid && i_in_valid[cand]) begin
            w_anyValid  = 1'b1;
            w_grantIdx  = cand;
            w_grantData = w_chanData[cand];
         end
      end
   end

   // Accept strobe: only the winning channel, only when the register can load,
   // and never during a reset cycle so no word is lost to the reset
   always_comb begin
      w_inReady = '0;
      if (!i_reset && w_load && w_anyValid)
         w_inReady[w_grantIdx] = 1'b1;
   end

   assign o_in_ready = w_inReady;

   // Output register and round-robin pointer. The pointer resets to the top
   // index so that channel 0 is first in line after reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outSel   <= '0;
         r_last     <= SEL_W'(CHANNELS - 1);
      end else if (w_load) begin
         if (w_anyValid) begin
            r_outValid <= 1'b1;
            r_outData  <= w_grantData;
            r_outSel   <= w_grantIdx;
            r_last     <= w_grantIdx;
         end else begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign o_out_valid = r_outValid;
   assign o_out_data  = r_outData;
   assign o_out_sel   = r_outSel;

endmodule
